// File: rtl/plru_ctrl.sv
// plru_ctrl: access and flush-sweep controller for the 4-way tree-PLRU file.
// Define PLRU_STATS_EN to build the saturating hit/miss counters.
module plru_ctrl #(
  parameter int NUM_SET = 16,
  parameter int SET_IDX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SET_IDX-1:0] req_set,
  input  logic               req_hit,
  input  logic [1:0]         req_way,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_way,
  input  logic               flush_req,
  output logic               flush_done,
  output logic [SET_IDX-1:0] plru_sr,
  input  logic [2:0]         plru_sv,
  output logic               regf_we,
  output logic [SET_IDX-1:0] plru_dr,
  output logic [2:0]         plru_dv,
  output logic [2:0]         plru_mask,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               s_valid_q, s_valid_d;
  logic [SET_IDX-1:0] s_set_q, s_set_d;
  logic               s_hit_q, s_hit_d;
  logic [1:0]         s_way_q, s_way_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_way_q, resp_way_d;
  logic [SET_IDX-1:0] cnt_q, cnt_d;
  logic               flush_done_q, flush_done_d;

  logic       s_fire;
  logic       accept;
  logic       sweep_last;
  logic [1:0] victim;
  logic [1:0] acc_way;

  assign s_fire     = s_valid_q && (!resp_valid_q || resp_ready);
  assign sweep_last = (state_q == SWEEP) &&
                      (cnt_q == SET_IDX'(NUM_SET - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s_valid_q    <= 1'b0;
      s_set_q      <= '0;
      s_hit_q      <= 1'b0;
      s_way_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_valid_q    <= s_valid_d;
      s_set_q      <= s_set_d;
      s_hit_q      <= s_hit_d;
      s_way_q      <= s_way_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_req) state_d = DRAIN;
      DRAIN:   if (!s_valid_q) state_d = SWEEP;
      SWEEP:   if (sweep_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !flush_req &&
                (!s_valid_q || s_fire);
    accept    = req_valid && req_ready;
    victim    = plru_sv[0] ? (plru_sv[2] ? 2'd3 : 2'd2)
                           : (plru_sv[1] ? 2'd1 : 2'd0);
    acc_way   = s_hit_q ? s_way_q : victim;

    s_valid_d = accept || (s_valid_q && !s_fire);
    s_set_d   = accept ? req_set : s_set_q;
    s_hit_d   = accept ? req_hit : s_hit_q;
    s_way_d   = accept ? req_way : s_way_q;

    // A fire in the same cycle keeps the response valid for the new way.
    resp_valid_d = s_fire || (resp_valid_q && !resp_ready);
    resp_way_d   = s_fire ? acc_way : resp_way_q;

    cnt_d        = (state_q == SWEEP && !sweep_last) ?
                   cnt_q + 1'b1 : '0;
    flush_done_d = sweep_last;
  end

  always_comb begin
    plru_sr   = s_valid_q ? s_set_q : '0;
    regf_we   = 1'b0;
    plru_dr   = s_set_q;
    plru_dv   = 3'b000;
    plru_mask = 3'b000;
    if (state_q == SWEEP) begin
      regf_we   = 1'b1;
      plru_dr   = cnt_q;
      plru_mask = 3'b111;
    end else if (s_fire) begin
      regf_we    = 1'b1;
      plru_dv[0] = ~acc_way[1];
      if (acc_way[1]) begin
        plru_dv[2] = ~acc_way[0];
        plru_mask  = 3'b101;
      end else begin
        plru_dv[1] = ~acc_way[0];
        plru_mask  = 3'b011;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_way   = resp_way_q;
  assign flush_done = flush_done_q;

`ifdef PLRU_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (s_fire && s_hit_q && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (s_fire && !s_hit_q && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_plru_ctrl.sv
// tb_plru_ctrl: random and directed checks of plru_ctrl against a
// transaction-level PLRU model, with a behavioural plrufile alongside.
module tb_plru_ctrl;

  localparam int NS = 16;
  localparam int SI = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_SWEEP = 2;
`ifdef PLRU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SI-1:0] req_set = '0;
  logic          req_hit = 1'b0;
  logic [1:0]    req_way = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [1:0]    resp_way;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic [SI-1:0] plru_sr;
  logic [2:0]    plru_sv;
  logic          regf_we;
  logic [SI-1:0] plru_dr;
  logic [2:0]    plru_dv;
  logic [2:0]    plru_mask;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  plru_ctrl #(.NUM_SET(NS), .SET_IDX(SI)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_hit(req_hit), .req_way(req_way),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_way(resp_way),
    .flush_req(flush_req), .flush_done(flush_done),
    .plru_sr(plru_sr), .plru_sv(plru_sv),
    .regf_we(regf_we), .plru_dr(plru_dr),
    .plru_dv(plru_dv), .plru_mask(plru_mask),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // plrufile: combinational read, masked write at the clock edge
  logic [2:0] pf [NS];
  assign plru_sv = pf[plru_sr];

  always @(posedge clk) begin
    if (regf_we === 1'b1)
      for (int b = 0; b < 3; b++)
        if (plru_mask[b]) pf[plru_dr][b] <= plru_dv[b];
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: per set, which pair holds the victim and which way per pair.
  int m_top [NS];
  int m_low [NS][2];
  int m_ph, m_cnt, m_set, m_way, m_rw;
  bit m_sv, m_hit, m_rv, m_fd, m_init;
  longint unsigned m_hc, m_mc;

  initial begin
    for (int i = 0; i < NS; i++) begin
      pf[i] = 3'b000;
      m_top[i] = 0;
      m_low[i][0] = 0;
      m_low[i][1] = 0;
    end
    m_ph = PH_IDLE; m_cnt = 0; m_set = 0; m_way = 0; m_rw = 0;
    m_sv = 0; m_hit = 0; m_rv = 0; m_fd = 0; m_init = 0;
    m_hc = 0; m_mc = 0;
  end

  always @(negedge clk) begin
    bit fire, rr, we, acc;
    int w, edr, edv, emk;
    fire = m_sv && (!m_rv || resp_ready);
    rr = (m_ph == PH_IDLE) && !flush_req && (!m_sv || fire);
    w = m_hit ? m_way : 2 * m_top[m_set] + m_low[m_set][m_top[m_set]];
    we = fire || (m_ph == PH_SWEEP);
    if (m_ph == PH_SWEEP) begin
      edr = m_cnt; edv = 0; emk = 7;
    end else begin
      edr = m_set;
      emk = (w < 2) ? 3 : 5;
      edv = (1 - w / 2) + ((1 - w % 2) << (1 + w / 2));
    end
    if (m_init) begin
      chk("req_ready", req_ready, rr);
      chk("resp_valid", resp_valid, m_rv);
      chk("resp_way", resp_way, m_rw);
      chk("flush_done", flush_done, m_fd);
      chk("regf_we", regf_we, we);
      chk("plru_sr", plru_sr, m_sv ? m_set : 0);
      chk("hit_cnt", hit_cnt, STATS ? m_hc : 64'd0);
      chk("miss_cnt", miss_cnt, STATS ? m_mc : 64'd0);
      if (we) begin
        chk("plru_dr", plru_dr, edr);
        chk("plru_mask", plru_mask, emk);
        chk("plru_dv", plru_dv & plru_mask, edv);
        if (m_ph == PH_SWEEP) begin
          m_top[m_cnt] = 0;
          m_low[m_cnt][0] = 0;
          m_low[m_cnt][1] = 0;
        end else begin
          m_top[m_set] = 1 - w / 2;
          m_low[m_set][w / 2] = 1 - w % 2;
        end
      end
    end
    if (rst) begin
      m_init = 1; m_ph = PH_IDLE; m_cnt = 0; m_sv = 0;
      m_rv = 0; m_rw = 0; m_fd = 0; m_hc = 0; m_mc = 0;
    end else if (m_init) begin
      acc = req_valid && rr;
      m_fd = (m_ph == PH_SWEEP) && (m_cnt == NS - 1);
      if (fire) begin
        m_rv = 1; m_rw = w;
        if (m_hit) begin
          if (m_hc < 64'hFFFF_FFFF) m_hc++;
        end else begin
          if (m_mc < 64'hFFFF_FFFF) m_mc++;
        end
      end else if (resp_ready) m_rv = 0;
      case (m_ph)
        PH_IDLE:  if (flush_req) m_ph = PH_DRAIN;
        PH_DRAIN: if (!m_sv) begin m_ph = PH_SWEEP; m_cnt = 0; end
        default:  if (m_cnt == NS - 1) m_ph = PH_IDLE; else m_cnt++;
      endcase
      if (acc) begin
        m_sv = 1; m_set = req_set; m_hit = req_hit; m_way = req_way;
      end else if (fire) m_sv = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input int s, input bit h, input int w,
                     output logic [1:0] rw, output logic [2:0] dv,
                     output logic [2:0] mk, output logic [SI-1:0] dr);
    req_valid = 1'b1; req_set = SI'(s); req_hit = h; req_way = 2'(w);
    tick;
    req_valid = 1'b0;
    @(negedge clk);
    dv = plru_dv; mk = plru_mask; dr = plru_dr;
    tick;
    @(negedge clk);
    rw = resp_way;
    tick;
  endtask

  initial begin
    logic [1:0] rw;
    logic [2:0] dv, mk;
    logic [SI-1:0] dr;
    int seq [4];
    int exp4 [4];
    int nw, fd_at;
    bit order_ok;
    exp4 = '{0, 2, 1, 3};

    tick; tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_regf_we", regf_we, 0);
    chk("rst_flush_done", flush_done, 0);
    tick;

    acc(3, 0, 0, rw, dv, mk, dr);
    chk("s3_victim0", rw, 0);
    chk("s3_dv", dv, 3'b011);
    chk("s3_mask", mk, 3'b011);
    chk("s3_dr", dr, 3);
    acc(3, 0, 0, rw, dv, mk, dr);
    chk("s3_victim1", rw, 2);

    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4); req_set = 5; req_hit = 1'b0;
      @(negedge clk);
      if (i >= 2) seq[i - 2] = resp_way;
      tick;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk("s5_seq", seq[i], exp4[i]);

    acc(7, 1, 2, rw, dv, mk, dr);
    chk("s7_hit_way", rw, 2);
    chk("s7_dv", dv & 3'b101, 3'b100);
    chk("s7_mask", mk, 3'b101);
    acc(7, 0, 0, rw, dv, mk, dr);
    chk("s7_victim", rw, 0);

    resp_ready = 1'b0; req_valid = 1'b1; req_set = 9; req_hit = 1'b0;
    tick;
    req_set = 10;
    tick;
    req_set = 11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_way", resp_way, 0);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_regf_we", regf_we, 0);
      tick;
    end
    resp_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (3) tick;

    for (int i = 0; i < NS; i++) begin
      req_valid = 1'b1; req_set = SI'(i); req_hit = 1'b0;
      tick;
    end
    req_valid = 1'b0;
    repeat (3) tick;
    flush_req = 1'b1; req_valid = 1'b1; req_set = 4;
    @(negedge clk);
    chk("flush_beats_req", req_ready, 0);
    tick;
    flush_req = 1'b0; req_valid = 1'b0;
    nw = 0; fd_at = -1; order_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (regf_we === 1'b1) begin
        if (plru_dr !== SI'(nw) || plru_dv !== 3'b000 ||
            plru_mask !== 3'b111) order_ok = 1'b0;
        nw++;
      end
      if (flush_done === 1'b1 && fd_at < 0) fd_at = k;
      tick;
    end
    chk("sweep_writes", nw, NS);
    chk("sweep_order", order_ok, 1);
    chk("flush_done_cycle", fd_at, NS + 2);
    acc(11, 0, 0, rw, dv, mk, dr);
    chk("post_flush_victim", rw, 0);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    acc(1, 1, 1, rw, dv, mk, dr);
    acc(2, 1, 3, rw, dv, mk, dr);
    acc(3, 1, 0, rw, dv, mk, dr);
    acc(4, 0, 0, rw, dv, mk, dr);
    acc(5, 0, 0, rw, dv, mk, dr);
    @(negedge clk);
    chk("stats_hit", hit_cnt, STATS ? 3 : 0);
    chk("stats_miss", miss_cnt, STATS ? 2 : 0);
    tick;

    flush_req = 1'b1;
    tick;
    flush_req = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_sweep_we", regf_we, 1);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sweep_we", regf_we, 0);
    chk("rst_sweep_ready", req_ready, 1);
    chk("rst_sweep_resp", resp_valid, 0);
    chk("rst_sweep_hit", hit_cnt, 0);
    chk("rst_sweep_miss", miss_cnt, 0);
    tick;

    for (int c = 0; c < 4000; c++) begin
      req_valid  = ($urandom_range(0, 9) < 6);
      req_set    = SI'($urandom);
      req_hit    = 1'($urandom);
      req_way    = 2'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush_req  = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 599) == 0);
      tick;
    end
    req_valid = 1'b0; flush_req = 1'b0; rst = 1'b0; resp_ready = 1'b1;
    repeat (25) tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/plru_ctrl.md
# plru_ctrl

Controller on the access side of the 4-way tree-PLRU state file (`plrufile`). It accepts per-set access requests from the cache, reads the set's 3 PLRU bits, returns the victim way on misses or echoes the way on hits, and writes the updated bits back through `plrufile`'s masked write port. It also runs a flush sweep that clears every set's PLRU state one set per cycle.

## Interface
- `NUM_SET`, default 16: number of sets; must equal `plrufile.NUM_SET`.
- `SET_IDX`, default 4: set index width, `log2(NUM_SET)`.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: access request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_set` in SET_IDX: set index.
- `req_hit` in 1: 1 means hit to `req_way`; 0 means miss, victim requested.
- `req_way` in 2: hit way; ignored on miss.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: consumer accepts the response.
- `resp_way` out 2: hit way (echoed) or chosen victim.
- `flush_req` in 1: one-cycle pulse requesting a clear of all sets.
- `flush_done` out 1: one-cycle pulse when the sweep completes.
- `plru_sr` out SET_IDX: read set index to `plrufile`.
- `plru_sv` in 3: PLRU bits of `plru_sr`, combinational from `plrufile`.
- `regf_we`, `plru_dr`, `plru_dv`, `plru_mask` out 1/SET_IDX/3/3: write port to `plrufile`.
- `hit_cnt`, `miss_cnt` out 32/32: statistics; see Configuration.

## Operation
- **Tree encoding:**
  - `sv[0]=0` puts the victim in ways 0–1; `sv[0]=1` puts it in ways 2–3.
  - `sv[1]` picks way 1 over way 0 when set. `sv[2]` picks way 3 over way 2 when set.
  - Victim is `sv[0] ? (sv[2] ? 3 : 2) : (sv[1] ? 1 : 0)`.
- **Update on access to way w** (hit way or the victim):
  - `dv[0] = ~w[1]`.
  - If `w[1]=0`: `dv[1] = ~w[0]`, `mask = 3'b011`.
  - If `w[1]=1`: `dv[2] = ~w[0]`, `mask = 3'b101`.
- **Stage S** is a single register holding `valid`, `set`, `hit`, `way`. `plru_sr = S.set` whenever S is valid; otherwise it is 0.
- **S fires** when `S.valid && (!resp_valid || resp_ready)`. On fire:
  - `regf_we=1`, `plru_dr=S.set`, with `dv` and `mask` computed from that cycle's `plru_sv`.
  - The response register loads `resp_way`.
  - Hit and miss counters update.
- **Acceptance:** `req_ready = (state==IDLE) && !flush_req && (!S.valid || S_fires)`. An accepted request loads S.
- **Response handshake:** `resp_valid` sets when S fires. It clears when `resp_ready` is high and S does not fire in the same cycle.
- **FSM states:** IDLE, DRAIN, SWEEP.
  - IDLE → DRAIN on `flush_req`. `flush_req` is ignored outside IDLE.
  - DRAIN → SWEEP once S is empty.
  - SWEEP writes `dv=000`, `mask=111`, `plru_dr=cnt` each cycle, with `cnt` running 0..NUM_SET-1.
  - After the write of `cnt=NUM_SET-1`, the FSM returns to IDLE and pulses `flush_done` in the next cycle.
- **Boundary cases:**
  - `flush_req` together with `req_valid` in IDLE: flush wins and the request is not accepted.
  - An outstanding response is not discarded by a flush.
  - The sweep counter wraps by ending the sweep, not by rolling over.
- **Reset values:**
  - `state=IDLE`, `S.valid=0`, `resp_valid=0`, `resp_way=0`.
  - `flush_done=0`, `regf_we=0`, counters 0.
  - `req_ready=1` in the first post-reset cycle.
- **Reset mid-sweep or mid-request:** all of the above reset values apply in the next cycle. The in-flight request and its response are lost.

## Timing
- Request accepted at edge N. S is valid in cycle N+1, and the `plrufile` write lands at edge N+1. `resp_valid` is high in cycle N+2.
- Throughput is 1 request per cycle while `resp_ready=1`.
- A back-to-back same-set request reads the updated bits, because the write lands before S reads. No forwarding is needed.
- `resp_ready=0` with S valid: S stalls, `regf_we=0`, and `req_ready=0`.
- A flush from IDLE with S empty takes `NUM_SET` SWEEP cycles plus 1 DRAIN cycle. `flush_done` comes at cycle `NUM_SET+2` after the `flush_req` cycle.

## Configuration
- **`PLRU_STATS_EN` defined:**
  - `hit_cnt` and `miss_cnt` are 32-bit saturating counters (stop at `32'hFFFF_FFFF`).
  - Each increments by 1 on an S fire with `hit=1` or `hit=0` respectively.
  - Both clear on `rst` and are not cleared by a flush.
- **`PLRU_STATS_EN` not defined:** both ports are constant 0 and no counter flops are generated.

## Test plan
- After reset, miss to set 3 → `resp_way=0`; write `dv=3'b011`, `mask=3'b011`, `dr=3`. Next miss to set 3 → `resp_way=2`.
- Four consecutive misses to set 5 from reset, back-to-back → `resp_way` sequence 0, 2, 1, 3, one per cycle.
- Hit way 2 on set 7 from `sv=000` → `dv[0]=0`, `dv[2]=1`, `mask=3'b101`. Next miss on set 7 → victim 0.
- Request with `resp_ready=0` for 3 cycles → `resp_valid` held, `resp_way` stable, second request held off (`req_ready=0`), no extra `regf_we`.
- Prime sets 0..15 with misses, then `flush_req` → 16 writes of `dv=000`, `mask=111` to sets 0..15 in order, `flush_done` 18 cycles after `flush_req`. Any subsequent miss → way 0.
- With `PLRU_STATS_EN`: 3 hits + 2 misses → `hit_cnt=3`, `miss_cnt=2`. `rst` asserted mid-sweep → counters 0, state IDLE, `regf_we=0` in the next cycle.
